// File: rtl/burst_arb_pkg.sv
// Shared types and helpers for the frame-granular burst stream arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package burst_arb_pkg;

    // Arbiter FSM states: waiting for a SOF, or holding a frame grant for one source
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    // Bit of tuser that marks the first burst of a frame
    localparam int SOF_BIT = 0;

    // Number of input beats that make up one frame
    function automatic int bursts_per_frame(input int rows, input int cols, input int ppb);
        return (rows * cols) / ppb;
    endfunction

endpackage

// File: rtl/rr_frame_arbiter.sv
// Round-robin frame grant FSM: picks a source on its SOF beat and holds it for one whole frame.
// Latency: grant is registered; the granted SOF beat transfers the cycle after IDLE sees it.
// Backpressure: frame progress advances only on master handshakes; stalls simply hold burst_cnt.
module rr_frame_arbiter
    import burst_arb_pkg::*;
#(
    parameter int BURSTS_PER_FRAME = 40
) (
    input  logic       clk,
    input  logic       s_axis_resetn,
    input  logic [1:0] sof_req,
    input  logic       beat_hs,
    input  logic       beat_sof,
    output logic [1:0] grant,
    output logic       frame_done,
    output logic       mid_sof
);

    // A one-beat frame still needs a one-bit counter to keep the logic well formed
    localparam int BCW = (BURSTS_PER_FRAME > 1) ? $clog2(BURSTS_PER_FRAME) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURSTS_PER_FRAME - 1);

    arb_state_t     state;
    logic           last_grant;
    logic [BCW-1:0] burst_cnt;
    logic           pick1;

    // A SOF on the granted source while a frame is underway is a protocol error;
    // it restarts the frame, so it can never also be the closing beat.
    assign mid_sof    = beat_hs && beat_sof && (burst_cnt != '0);
    assign frame_done = beat_hs && !mid_sof && (burst_cnt == LAST_BEAT);

    // Source 1 wins when it alone has a SOF, or on a tie when source 0 went last
    assign pick1 = sof_req[1] && (!sof_req[0] || !last_grant);

    // Grant FSM: IDLE waits for a SOF, GRANTn counts bursts until the frame closes
    always_ff @(posedge clk) begin
        if (!s_axis_resetn) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            burst_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    if (|sof_req) begin
                        state <= pick1 ? GRANT1 : GRANT0;
                        grant <= pick1 ? 2'b10 : 2'b01;
                    end
                end
                GRANT0, GRANT1: begin
                    if (mid_sof) begin
                        // The offending SOF is beat 0 of a fresh frame
                        burst_cnt <= BCW'(1);
                    end else if (frame_done) begin
                        burst_cnt  <= '0;
                        last_grant <= (state == GRANT1);
                        state      <= IDLE;
                        grant      <= 2'b00;
                    end else if (beat_hs) begin
                        burst_cnt <= burst_cnt + BCW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant     <= 2'b00;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/burst_stream_arbiter.sv
// Shares one sequentializer port between two burst streams, one whole frame at a time.
// Latency: zero-latency data mux; one dead cycle in IDLE between consecutive frames.
// Backpressure: granted source sees m_axis_tready; other source stalled (or drained if DROP_OTHER).
module burst_stream_arbiter
    import burst_arb_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH  = 10,
    parameter int PIXELS_PER_BURST = 10,
    parameter int USER_WIDTH       = 2,
    parameter int IN_ROWS          = 20,
    parameter int IN_COLS          = 20,
    parameter int DROP_OTHER       = 0,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                                        clk,
    input  logic                                        s_axis_resetn,
    input  logic                                        s0_axis_tvalid,
    output logic                                        s0_axis_tready,
    input  logic [PIXEL_BIT_WIDTH*PIXELS_PER_BURST-1:0] s0_axis_tdata,
    input  logic [USER_WIDTH-1:0]                       s0_axis_tuser,
    input  logic                                        s1_axis_tvalid,
    output logic                                        s1_axis_tready,
    input  logic [PIXEL_BIT_WIDTH*PIXELS_PER_BURST-1:0] s1_axis_tdata,
    input  logic [USER_WIDTH-1:0]                       s1_axis_tuser,
    output logic                                        m_axis_tvalid,
    input  logic                                        m_axis_tready,
    output logic [PIXEL_BIT_WIDTH*PIXELS_PER_BURST-1:0] m_axis_tdata,
    output logic [USER_WIDTH-1:0]                       m_axis_tuser,
    output logic                                        m_axis_tid,
    output logic                                        grant_active,
    output logic [CNT_WIDTH-1:0]                        frame_cnt0,
    output logic [CNT_WIDTH-1:0]                        frame_cnt1,
    output logic [CNT_WIDTH-1:0]                        drop_cnt,
    output logic                                        sof_err
);

    localparam int BURSTS_PER_FRAME = bursts_per_frame(IN_ROWS, IN_COLS, PIXELS_PER_BURST);

    logic [1:0] grant;
    logic [1:0] sof_req;
    logic       sel1;
    logic       beat_hs;
    logic       beat_sof;
    logic       frame_done;
    logic       mid_sof;
    logic       drop_sof;

    // Only a SOF can open a grant; non-SOF beats in IDLE are stale and get flushed
    assign sof_req[0] = s0_axis_tvalid && s0_axis_tuser[SOF_BIT];
    assign sof_req[1] = s1_axis_tvalid && s1_axis_tuser[SOF_BIT];

    rr_frame_arbiter #(
        .BURSTS_PER_FRAME (BURSTS_PER_FRAME)
    ) u_arb (
        .clk           (clk),
        .s_axis_resetn (s_axis_resetn),
        .sof_req       (sof_req),
        .beat_hs       (beat_hs),
        .beat_sof      (beat_sof),
        .grant         (grant),
        .frame_done    (frame_done),
        .mid_sof       (mid_sof)
    );

    // Zero-latency mux; with no grant it rests on source 0 and holds tvalid low
    assign sel1          = grant[1];
    assign grant_active  = |grant;
    assign m_axis_tid    = sel1;
    assign m_axis_tdata  = sel1 ? s1_axis_tdata : s0_axis_tdata;
    assign m_axis_tuser  = sel1 ? s1_axis_tuser : s0_axis_tuser;
    assign m_axis_tvalid = (grant[0] && s0_axis_tvalid) || (grant[1] && s1_axis_tvalid);

    assign beat_hs  = m_axis_tvalid && m_axis_tready;
    assign beat_sof = m_axis_tuser[SOF_BIT];

    // Source readies: flush stale beats in IDLE, follow the master when granted,
    // and either stall or drain the losing source during a grant
    always_comb begin
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        if (!grant_active) begin
            s0_axis_tready = !s0_axis_tuser[SOF_BIT];
            s1_axis_tready = !s1_axis_tuser[SOF_BIT];
        end else begin
            s0_axis_tready = grant[0] ? m_axis_tready : (DROP_OTHER != 0);
            s1_axis_tready = grant[1] ? m_axis_tready : (DROP_OTHER != 0);
        end
    end

    // A discarded frame is counted by its SOF beat on the drained source
    assign drop_sof = (grant[0] && s1_axis_tvalid && s1_axis_tready && s1_axis_tuser[SOF_BIT]) ||
                      (grant[1] && s0_axis_tvalid && s0_axis_tready && s0_axis_tuser[SOF_BIT]);

    // Status counters: wrap freely; frame end and drop may land in the same cycle
    always_ff @(posedge clk) begin
        if (!s_axis_resetn) begin
            frame_cnt0 <= '0;
            frame_cnt1 <= '0;
            drop_cnt   <= '0;
        end else begin
            if (frame_done && !sel1) begin
                frame_cnt0 <= frame_cnt0 + CNT_WIDTH'(1);
            end
            if (frame_done && sel1) begin
                frame_cnt1 <= frame_cnt1 + CNT_WIDTH'(1);
            end
            if (drop_sof) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Sticky protocol error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!s_axis_resetn) begin
            sof_err <= 1'b0;
        end else if (mid_sof) begin
            sof_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_burst_stream_arbiter.sv
// Self-checking bench for burst_stream_arbiter with a 4-burst frame geometry.
// Latency: checks the one-cycle IDLE-to-transfer delay and the single dead cycle between frames.
// Backpressure: exercises toggling master ready, stalled and drained losing sources.
`timescale 1ns/1ps
module tb_burst_stream_arbiter;

    localparam int PBW  = 10;
    localparam int PPB  = 10;
    localparam int UW   = 2;
    localparam int ROWS = 4;
    localparam int COLS = 10;
    localparam int CW   = 16;
    localparam int DW   = PBW * PPB;

    typedef struct packed {
        logic          tid;
        logic [UW-1:0] u;
        logic [DW-1:0] d;
    } beat_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- DUT A: losing source is back-pressured ----------------
    logic          s0_valid, s0_ready, s1_valid, s1_ready;
    logic [DW-1:0] s0_data, s1_data, m_data;
    logic [UW-1:0] s0_user, s1_user, m_user;
    logic          m_valid, m_ready, m_tid, grant_active, sof_err;
    logic [CW-1:0] fc0, fc1, drop;
    logic          rdy_toggle = 1'b0;
    logic          tog        = 1'b0;

    assign m_ready = rdy_toggle ? tog : 1'b1;
    always @(posedge clk) begin
        #1;
        tog = ~tog;
    end

    burst_stream_arbiter #(
        .PIXEL_BIT_WIDTH (PBW), .PIXELS_PER_BURST (PPB), .USER_WIDTH (UW),
        .IN_ROWS (ROWS), .IN_COLS (COLS), .DROP_OTHER (0), .CNT_WIDTH (CW)
    ) dut_a (
        .clk (clk), .s_axis_resetn (resetn),
        .s0_axis_tvalid (s0_valid), .s0_axis_tready (s0_ready),
        .s0_axis_tdata (s0_data), .s0_axis_tuser (s0_user),
        .s1_axis_tvalid (s1_valid), .s1_axis_tready (s1_ready),
        .s1_axis_tdata (s1_data), .s1_axis_tuser (s1_user),
        .m_axis_tvalid (m_valid), .m_axis_tready (m_ready),
        .m_axis_tdata (m_data), .m_axis_tuser (m_user), .m_axis_tid (m_tid),
        .grant_active (grant_active), .frame_cnt0 (fc0), .frame_cnt1 (fc1),
        .drop_cnt (drop), .sof_err (sof_err)
    );

    // ---------------- DUT B: losing source is drained ----------------
    logic          b_s0_valid = 1'b0, b_s1_valid = 1'b0, b_m_ready = 1'b1;
    logic          b_s0_ready, b_s1_ready, b_m_valid, b_m_tid, b_grant_active, b_sof_err;
    logic [DW-1:0] b_s0_data = '0, b_s1_data = '0, b_m_data;
    logic [UW-1:0] b_s0_user = '0, b_s1_user = '0, b_m_user;
    logic [CW-1:0] b_fc0, b_fc1, b_drop;

    burst_stream_arbiter #(
        .PIXEL_BIT_WIDTH (PBW), .PIXELS_PER_BURST (PPB), .USER_WIDTH (UW),
        .IN_ROWS (ROWS), .IN_COLS (COLS), .DROP_OTHER (1), .CNT_WIDTH (CW)
    ) dut_b (
        .clk (clk), .s_axis_resetn (resetn),
        .s0_axis_tvalid (b_s0_valid), .s0_axis_tready (b_s0_ready),
        .s0_axis_tdata (b_s0_data), .s0_axis_tuser (b_s0_user),
        .s1_axis_tvalid (b_s1_valid), .s1_axis_tready (b_s1_ready),
        .s1_axis_tdata (b_s1_data), .s1_axis_tuser (b_s1_user),
        .m_axis_tvalid (b_m_valid), .m_axis_tready (b_m_ready),
        .m_axis_tdata (b_m_data), .m_axis_tuser (b_m_user), .m_axis_tid (b_m_tid),
        .grant_active (b_grant_active), .frame_cnt0 (b_fc0), .frame_cnt1 (b_fc1),
        .drop_cnt (b_drop), .sof_err (b_sof_err)
    );

    // ---------------- source drivers for DUT A ----------------
    beat_t src0_mem [64];
    beat_t src1_mem [64];
    int    wr0 = 0, wr1 = 0;   // written by the stimulus
    int    rd0 = 0, rd1 = 0;   // advanced by the drivers on source handshakes

    initial begin
        bit h0, h1;
        s0_valid = 1'b0; s0_data = '0; s0_user = '0;
        s1_valid = 1'b0; s1_data = '0; s1_user = '0;
        forever begin
            @(negedge clk);
            h0 = resetn && s0_valid && s0_ready;
            h1 = resetn && s1_valid && s1_ready;
            @(posedge clk);
            if (h0) rd0++;
            if (h1) rd1++;
            #1;
            s0_valid = (rd0 != wr0);
            s0_data  = src0_mem[rd0 % 64].d;
            s0_user  = src0_mem[rd0 % 64].u;
            s1_valid = (rd1 != wr1);
            s1_data  = src1_mem[rd1 % 64].d;
            s1_user  = src1_mem[rd1 % 64].u;
        end
    end

    // ---------------- scoreboard and checking ----------------
    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    beats_seen = 0;
    bit    gap_en = 1'b0;
    bit    have_prev = 1'b0;
    logic  prev_tid = 1'b0;
    int    prev_cyc = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int src, input int tag, input int k);
        logic [DW-1:0] d;
        d = '0;
        d[23:0]      = {8'(src), 8'(tag), 8'(k)};
        d[DW-1 -: 8] = 8'hC3 ^ 8'(k);
        return d;
    endfunction

    // Queue a frame on a source; the first n_exp beats are expected on the master
    task automatic send_frame(input int src, input int tag, input int nbeats,
                              input int mid_sof, input int n_exp);
        beat_t b;
        for (int k = 0; k < nbeats; k++) begin
            b.tid = src[0];
            b.u   = {1'(k % 2), 1'(k == 0 || k == mid_sof)};
            b.d   = mk_data(src, tag, k);
            if (src == 0) begin
                src0_mem[wr0 % 64] = b;
                wr0++;
            end else begin
                src1_mem[wr1 % 64] = b;
                wr1++;
            end
            if (k < n_exp) exp_q.push_back(b);
        end
    endtask

    // Advance to the next negedge and score any master beat completing this cycle
    task automatic tick();
        beat_t ob, eb;
        @(negedge clk);
        if (resetn && m_valid && m_ready) begin
            ob = {m_tid, m_user, m_data};
            beats_seen++;
            chk("beat_expected", 1'(exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
                eb = exp_q.pop_front();
                chk("beat", ob, eb);
            end
            if (gap_en && have_prev && (m_tid != prev_tid)) begin
                chk("dead_gap", cyc - prev_cyc, 2);
            end
            have_prev = 1'b1;
            prev_tid  = m_tid;
            prev_cyc  = cyc;
        end
    endtask

    task automatic wait_drain(input string tag, output int ga_cycles);
        bit done;
        done = 1'b0;
        ga_cycles = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (grant_active) ga_cycles++;
            done = (rd0 == wr0) && (rd1 == wr1) && (exp_q.size() == 0) && !grant_active;
        end
        chk({tag, "_drain"}, done, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1; resetn = 1'b0;
        @(posedge clk); #1; resetn = 1'b1;
        tick();
        chk("rst_mvalid", m_valid, 1'b0);
        chk("rst_grant", grant_active, 1'b0);
        chk("rst_tid", m_tid, 1'b0);
        chk("rst_fc0", fc0, 0);
        chk("rst_fc1", fc1, 0);
        chk("rst_drop", drop, 0);
        chk("rst_sof_err", sof_err, 1'b0);
        have_prev = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int    ga;
        int    base;
        bit    reached;
        beat_t eb;

        // Reset state
        do_reset();

        // Single source frame: 1-cycle SOF latency, 4 beats, grant drops after beat 4
        send_frame(0, 1, 4, -1, 4);
        tick();
        chk("t1_idle_mvalid", m_valid, 1'b0);
        chk("t1_sof_held", s0_ready, 1'b0);
        tick();
        chk("t1_first_valid", m_valid, 1'b1);
        chk("t1_grant", grant_active, 1'b1);
        chk("t1_tid", m_tid, 1'b0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("t1_grant_hold", grant_active, 1'b1);
        end
        tick();
        chk("t1_grant_drop", grant_active, 1'b0);
        chk("t1_fc0", fc0, 1);

        // Tie from reset: s0 first, then s1, then the queued s0 frame
        do_reset();
        gap_en = 1'b1;
        send_frame(0, 2, 4, -1, 4);
        send_frame(1, 3, 4, -1, 4);
        send_frame(0, 4, 4, -1, 4);
        wait_drain("t2", ga);
        gap_en = 1'b0;
        chk("t2_fc0", fc0, 2);
        chk("t2_fc1", fc1, 1);

        // Backpressure on an s1 frame
        rdy_toggle = 1'b1;
        send_frame(1, 5, 4, -1, 4);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (grant_active) begin
                chk("t3_s1_ready_mirror", s1_ready, m_ready);
                chk("t3_s0_stalled", s0_ready, 1'b0);
            end
        end
        wait_drain("t3", ga);
        rdy_toggle = 1'b0;
        chk("t3_fc1", fc1, 2);

        // SOF on the third beat restarts the frame: 6 beats in one grant
        chk("t5_sof_err_before", sof_err, 1'b0);
        send_frame(0, 6, 6, 2, 6);
        wait_drain("t5", ga);
        chk("t5_grant_len", ga, 6);
        chk("t5_sof_err", sof_err, 1'b1);
        chk("t5_fc0", fc0, 3);

        // Reset after two beats; leftover non-SOF beats are flushed in IDLE
        send_frame(0, 7, 4, -1, 2);
        base = beats_seen;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            tick();
            reached = (beats_seen == base + 2);
        end
        chk("t6_two_beats", reached, 1'b1);
        @(posedge clk); #1; resetn = 1'b0;
        @(posedge clk); #1; resetn = 1'b1;
        tick();
        chk("t6_grant", grant_active, 1'b0);
        chk("t6_mvalid", m_valid, 1'b0);
        chk("t6_fc0", fc0, 0);
        chk("t6_fc1", fc1, 0);
        chk("t6_sof_err", sof_err, 1'b0);
        chk("t6_stale_valid", s0_valid, 1'b1);
        chk("t6_stale_nonsof", s0_user[0], 1'b0);
        chk("t6_stale_flush", s0_ready, 1'b1);
        wait_drain("t6", ga);
        chk("t6_no_extra_beats", beats_seen, base + 2);

        // DROP_OTHER=1: s1 frame arrives during an s0 grant and is discarded
        @(posedge clk); #1;
        b_s0_valid = 1'b1; b_s0_data = mk_data(0, 9, 0); b_s0_user = 2'b01;
        @(negedge clk);
        chk("t4_sof_held", b_s0_ready, 1'b0);
        chk("t4_idle_mvalid", b_m_valid, 1'b0);
        @(posedge clk); #1;
        b_s1_valid = 1'b1; b_s1_data = mk_data(1, 9, 0); b_s1_user = 2'b01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            eb.tid = 1'b0;
            eb.u   = (k == 0) ? 2'b01 : 2'b00;
            eb.d   = mk_data(0, 9, k);
            chk("t4_mvalid", b_m_valid, 1'b1);
            chk("t4_beat", {b_m_tid, b_m_user, b_m_data}, eb);
            chk("t4_s1_drained", b_s1_ready, 1'b1);
            @(posedge clk); #1;
            if (k < 3) begin
                b_s0_data = mk_data(0, 9, k + 1); b_s0_user = 2'b00;
                b_s1_data = mk_data(1, 9, k + 1); b_s1_user = 2'b00;
            end else begin
                b_s0_valid = 1'b0;
                b_s1_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("t4_drop_cnt", b_drop, 1);
        chk("t4_fc0", b_fc0, 1);
        chk("t4_fc1", b_fc1, 0);
        chk("t4_grant_drop", b_grant_active, 1'b0);
        chk("t4_sof_err", b_sof_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_stream_arbiter.md
Name: burst_stream_arbiter

Overview:
- Frame-granular round-robin arbiter that shares one sequentializer between two burst-wide AXI-Stream camera sources.
- Sits between two CoaxPress burst streams and the sequentializer slave port in CustomLogic.
- A grant is issued only on a start-of-frame beat (tuser[0]=1) and is held for exactly one whole frame of bursts, so the sequentializer never sees interleaved frames.
- Counts delivered and dropped frames per source and flags SOF protocol errors.

Parameters:
- PIXEL_BIT_WIDTH, 10, bits per pixel.
- PIXELS_PER_BURST, 10, pixels per input beat.
- USER_WIDTH, 2, tuser width; bit 0 = start of frame.
- IN_ROWS, 20, frame rows.
- IN_COLS, 20, frame columns; IN_ROWS*IN_COLS must be a multiple of PIXELS_PER_BURST.
- DROP_OTHER, 0, 1 = the non-granted source is drained and discarded; 0 = it is back-pressured.
- CNT_WIDTH, 16, status counter width.

Ports:
- clk  in  1  clock.
- s_axis_resetn  in  1  synchronous active-low reset.
- s0_axis_tvalid  in  1  source 0 valid.
- s0_axis_tready  out  1  source 0 ready.
- s0_axis_tdata  in  PIXEL_BIT_WIDTH*PIXELS_PER_BURST  source 0 burst.
- s0_axis_tuser  in  USER_WIDTH  source 0 user; bit 0 = SOF.
- s1_axis_tvalid / s1_axis_tready / s1_axis_tdata / s1_axis_tuser  as s0  source 1.
- m_axis_tvalid  out  1  to sequentializer.
- m_axis_tready  in  1  from sequentializer.
- m_axis_tdata  out  PIXEL_BIT_WIDTH*PIXELS_PER_BURST  muxed burst.
- m_axis_tuser  out  USER_WIDTH  muxed user.
- m_axis_tid  out  1  source index of the current beat.
- grant_active  out  1  a frame is in progress.
- frame_cnt0, frame_cnt1  out  CNT_WIDTH  completed frames per source.
- drop_cnt  out  CNT_WIDTH  SOF beats discarded (DROP_OTHER=1 only).
- sof_err  out  1  sticky error: SOF seen mid-frame.

Behaviour:
- BURSTS_PER_FRAME = IN_ROWS*IN_COLS/PIXELS_PER_BURST (localparam). burst_cnt is $clog2(BURSTS_PER_FRAME) bits wide.
- States: IDLE, GRANT0, GRANT1. Register last_grant, reset value 1, so source 0 wins the first tie.
- Reset (s_axis_resetn=0 at a clk edge):
  - state=IDLE; burst_cnt, frame_cnt0/1, drop_cnt and sof_err all 0.
  - Outputs after reset: m_axis_tvalid=0, grant_active=0, m_axis_tid=0.
  - A reset mid-frame abandons the frame. No beat is completed and nothing is counted.
- Datapath: purely combinational mux with zero latency.
  - m_axis_tdata, m_axis_tuser and m_axis_tid follow the selected source.
  - In IDLE, m_axis_tvalid=0 and the mux selects source 0.
- IDLE:
  - A source presenting tvalid with tuser[0]=0 gets tready=1. These stale mid-frame beats are flushed and not counted.
  - SOF beats are held with tready=0.
  - If exactly one source holds a SOF, it is granted. If both do, the source != last_grant is granted.
  - The next state is GRANTn. The SOF beat itself transfers in GRANTn, so the IDLE-to-first-transfer delay is 1 cycle.
- GRANTn:
  - m_axis_tvalid = sn_tvalid; sn_tready = m_axis_tready; grant_active=1.
  - Each master handshake increments burst_cnt.
  - A handshake with burst_cnt == BURSTS_PER_FRAME-1 triggers frame end: burst_cnt<=0, frame_cntn++ (wraps), last_grant<=n, next state IDLE.
  - The other source:
    - DROP_OTHER=0: tready=0.
    - DROP_OTHER=1: tready=1, and each accepted beat with tuser[0]=1 increments drop_cnt (wraps).
  - A granted-source handshake with tuser[0]=1 while burst_cnt != 0 sets sof_err and treats the beat as a new frame: burst_cnt<=1, no frame_cnt increment.
- Simultaneous events:
  - A frame end and a pending SOF on the other source still pass through IDLE. The arbiter guarantees exactly 1 dead cycle between frames.
  - If the frame-end handshake coincides with a drop on the other source, both counters update.
- sof_err clears only on reset.

Decomposition:
- Package burst_arb_pkg holds:
  - the state enum typedef (IDLE, GRANT0, GRANT1);
  - a function bursts_per_frame(rows, cols, ppb);
  - the SOF bit index constant.
- One sub-module is natural: rr_frame_arbiter. It contains the FSM, last_grant and burst_cnt, and drives a one-hot grant. The top level holds the mux and the status counters.

Test Plan:
All scenarios use IN_ROWS=4, IN_COLS=10, PIXELS_PER_BURST=10, so BURSTS_PER_FRAME=4.
- Single source: s0 sends 4 beats (SOF on the first), m_axis_tready=1 -> 4 master beats with tid=0; frame_cnt0=1; grant_active drops the cycle after beat 4.
- Tie: s0 and s1 both present SOF from reset -> s0 frame first, 1 idle cycle, then s1 frame; frame_cnt0=1, frame_cnt1=1; a third s0 SOF then waits for round-robin order.
- Backpressure: m_axis_tready toggles 1/0 each cycle during an s1 frame -> no beat lost or duplicated; s1_axis_tready mirrors m_axis_tready; s0 tready=0 throughout.
- DROP_OTHER=1: s1 sends a full frame during an s0 grant -> s1 beats are accepted and discarded; drop_cnt=1; master shows only s0 data.
- Mid-frame SOF: s0 asserts SOF on its 3rd beat -> sof_err=1; the frame extends to 3 more beats before returning to IDLE; frame_cnt0=1.
- Reset after 2 beats of a grant -> IDLE, all counters 0; a stale non-SOF beat in IDLE is flushed with tready=1 and does not reach the master.
